// File: rtl/map_access_arbiter_pkg.sv
// Shared constants, sprite codes and controller state encoding for the map RAM arbiter.
package map_access_arbiter_pkg;

    localparam int MAP_W    = 21;
    localparam int MAP_H    = 21;
    localparam int MAP_SIZE = MAP_W * MAP_H;
    localparam int ADDR_W   = 9;
    localparam int SPRITE_W = 3;
    localparam int COORD_W  = 5;

    typedef enum logic [SPRITE_W-1:0] {
        BLACK     = 3'b000,
        BIG_ORB   = 3'b001,
        SMALL_ORB = 3'b010,
        WALL_BLUE = 3'b011,
        WALL_GREY = 3'b100
    } sprite_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    // Row-major tile address; callers only rely on it for in-range coordinates.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int row_w);
        return ADDR_W'(row_w * int'(y) + int'(x));
    endfunction

endpackage

// File: rtl/map_access_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after the pointer wins, wrapping around.
module rr_picker #(
    parameter int NPORT = 3,
    parameter int PW    = 2
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NPORT-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NPORT; i++) begin
            idx = (int'(ptr) + i) % NPORT;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_access_arbiter.sv
// Arbitrates display/Pac-Man/ghost access to the single-port map RAM and runs whole-map fills.
module map_access_arbiter #(
    parameter int MAP_W = map_access_arbiter_pkg::MAP_W,
    parameter int MAP_H = map_access_arbiter_pkg::MAP_H,
    parameter int NPORT = 3
) (
    input  logic                   clock_50,
    input  logic                   resetn,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT-1:0]       we,
    input  logic [NPORT-1:0][4:0]  map_x,
    input  logic [NPORT-1:0][4:0]  map_y,
    input  logic [NPORT-1:0][2:0]  wdata,
    output logic [NPORT-1:0]       gnt,
    output logic [NPORT-1:0]       rvalid,
    output logic [2:0]             rdata,
    output logic [NPORT-1:0]       err,
    input  logic                   fill_start,
    input  logic [2:0]             fill_value,
    output logic                   busy,
    output logic                   fill_done,
    output logic [8:0]             ram_addr,
    output logic [2:0]             ram_data,
    output logic                   ram_wren,
    input  logic [2:0]             ram_q
);
    import map_access_arbiter_pkg::*;

    localparam int          PW        = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [4:0]  X_LIM     = 5'(MAP_W);
    localparam logic [4:0]  Y_LIM     = 5'(MAP_H);
    localparam logic [8:0]  LAST_ADDR = 9'(MAP_W * MAP_H - 1);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NPORT-1:0]   gnt_q, gnt_d, err_q, err_d, rvalid_q, rvalid_d;
    logic [2:0]         rdata_q, rdata_d, ram_data_q, ram_data_d;
    logic [8:0]         ram_addr_q, ram_addr_d;
    logic               ram_wren_q, ram_wren_d, busy_q, busy_d, fill_done_q, fill_done_d;
    logic               s1_vld_q, s1_vld_d, s1_oob_q, s1_oob_d, s2_vld_q, s2_oob_q;
    logic [PW-1:0]      s1_port_q, s1_port_d, s2_port_q;
    logic [NPORT-1:0]   pick;
    logic [PW-1:0]      sel;
    logic               oob;

    // A port still sees its own req during the gnt cycle; mask it so it is not granted twice.
    rr_picker #(.NPORT(NPORT), .PW(PW)) u_rr_picker (
        .req (req & ~gnt_q),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (pick[i]) sel = PW'(i);
        end
        oob = (map_x[sel] >= X_LIM) || (map_y[sel] >= Y_LIM);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        err_d       = '0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_wren_d  = 1'b0;
        busy_d      = busy_q;
        fill_done_d = 1'b0;
        s1_vld_d    = 1'b0;
        s1_oob_d    = 1'b0;
        s1_port_d   = s1_port_q;
        rvalid_d    = '0;
        rdata_d     = '0;
        if (s2_vld_q) begin
            rvalid_d[s2_port_q] = 1'b1;
            rdata_d             = s2_oob_q ? 3'b000 : ram_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    state_d    = ST_FILL;
                    busy_d     = 1'b1;
                    ram_addr_d = '0;
                    ram_data_d = fill_value;
                    ram_wren_d = 1'b1;
                end else if (pick != '0) begin
                    gnt_d      = pick;
                    ptr_d      = sel;
                    err_d      = oob ? pick : '0;
                    ram_addr_d = tile_addr(map_x[sel], map_y[sel], MAP_W);
                    ram_data_d = wdata[sel];
                    ram_wren_d = we[sel] & ~oob;
                    s1_vld_d   = ~we[sel];
                    s1_oob_d   = oob;
                    s1_port_d  = sel;
                end
            end
            ST_FILL: begin
                if (ram_addr_q == LAST_ADDR) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    fill_done_d = 1'b1;
                end else begin
                    ram_addr_d = ram_addr_q + 9'd1;
                    ram_wren_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(NPORT - 1);
            gnt_q       <= '0;
            err_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_oob_q    <= 1'b0;
            s1_port_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_oob_q    <= 1'b0;
            s2_port_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_wren_q  <= ram_wren_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
            s1_vld_q    <= s1_vld_d;
            s1_oob_q    <= s1_oob_d;
            s1_port_q   <= s1_port_d;
            s2_vld_q    <= s1_vld_q;
            s2_oob_q    <= s1_oob_q;
            s2_port_q   <= s1_port_q;
        end
    end

    assign gnt       = gnt_q;
    assign err       = err_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_wren  = ram_wren_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Scoreboard bench for map_access_arbiter: tile-grid reference model, RAM model, random and directed traffic.
module tb_map_access_arbiter;
    import map_access_arbiter_pkg::*;

    logic             clock_50 = 1'b0;
    logic             resetn   = 1'b1;
    logic [2:0]       req, we, gnt, rvalid, err;
    logic [2:0][4:0]  map_x, map_y;
    logic [2:0][2:0]  wdata;
    logic [2:0]       rdata, fill_value, ram_data, ram_q;
    logic             fill_start, busy, fill_done, ram_wren;
    logic [8:0]       ram_addr;

    map_access_arbiter dut (
        .clock_50(clock_50), .resetn(resetn), .req(req), .we(we),
        .map_x(map_x), .map_y(map_y), .wdata(wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .err(err), .fill_start(fill_start),
        .fill_value(fill_value), .busy(busy), .fill_done(fill_done),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock_50 = ~clock_50;

    int cyc = 0;
    always @(posedge clock_50) cyc <= cyc + 1;

    // Map RAM: registers address/data/wren, read data one cycle after sampling.
    logic [2:0] mem [0:511];
    initial for (int i = 0; i < 512; i++) mem[i] = 3'((i * 7 + 3) % 5);
    always @(posedge clock_50) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    typedef struct { logic [2:0] data; int due; } exp_t;
    exp_t       exp_q [3][$];
    logic [2:0] model_map [0:20][0:20];
    int         total = 0, bad = 0;
    bit         c_we [3];
    int         c_x [3], c_y [3], c_d [3], issue_cyc [3], lat [3];
    int         grant_log [$];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clock_50) begin : monitor
        exp_t e;
        if ($countones(rvalid) > 1) chk("rvalid_onehot", $countones(rvalid), 1);
        for (int p = 0; p < 3; p++) begin
            if (rvalid[p]) begin
                if (exp_q[p].size() == 0) chk("rvalid_unexpected", 1, 0);
                else begin
                    e = exp_q[p].pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rvalid_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic start_cmd(input int p, input bit w, input int x, input int y, input int d);
        req[p] = 1'b1; we[p] = w; map_x[p] = 5'(x); map_y[p] = 5'(y); wdata[p] = 3'(d);
        c_we[p] = w; c_x[p] = x; c_y[p] = y; c_d[p] = d; issue_cyc[p] = cyc;
    endtask

    task automatic start_random(input int p);
        start_cmd(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 21)),
                  int'($urandom_range(0, 21)), int'($urandom_range(0, 7)));
    endtask

    task automatic accept(input int p);
        bit oob = (c_x[p] >= MAP_W) || (c_y[p] >= MAP_H);
        exp_t e;
        lat[p] = cyc - issue_cyc[p];
        grant_log.push_back(p);
        chk("err", err, oob ? (1 << p) : 0);
        chk("ram_wren", ram_wren, (c_we[p] && !oob) ? 1 : 0);
        if (!oob) chk("ram_addr", ram_addr, c_y[p] * MAP_W + c_x[p]);
        if (c_we[p] && !oob) begin
            chk("ram_data", ram_data, c_d[p]);
            model_map[c_y[p]][c_x[p]] = 3'(c_d[p]);
        end
        if (!c_we[p]) begin
            e.data = oob ? BLACK : model_map[c_y[p]][c_x[p]];
            e.due  = cyc + 2;
            exp_q[p].push_back(e);
        end
    endtask

    // renew: 0 = no new commands, 1 = random new commands, 2 = every idle port re-requests
    task automatic service(input int renew);
        if (gnt != 3'b000) chk("gnt_onehot", ($countones(gnt) == 1) ? 1 : 0, 1);
        for (int p = 0; p < 3; p++) begin
            if (gnt[p]) begin
                if (!req[p]) chk("gnt_without_req", 1, 0);
                else accept(p);
                req[p] = 1'b0;
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (!req[p] && (renew == 2 || (renew == 1 && $urandom_range(0, 2) == 0)))
                start_random(p);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clock_50);
            service(0);
            if (req == 3'b000 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[2].size() == 0) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_err"}, err, 0);        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_busy"}, busy, 0);      chk({tag, "_fill_done"}, fill_done, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0); chk({tag, "_ram_data"}, ram_data, 0);
        chk({tag, "_ram_wren"}, ram_wren, 0);
    endtask

    task automatic apply_reset();
        @(posedge clock_50);
        #2 resetn = 1'b0;
        req = '0; fill_start = 1'b0;
        #1 check_all_zero("rst");
        for (int p = 0; p < 3; p++) exp_q[p].delete();
        repeat (2) @(negedge clock_50);
        resetn = 1'b1;
    endtask

    initial begin : main
        int k, done, gb, cb, cr, cw;
        bit got;
        req = '0; we = '0; map_x = '0; map_y = '0; wdata = '0;
        fill_start = 1'b0; fill_value = '0;
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                model_map[y][x] = 3'(((MAP_W * y + x) * 7 + 3) % 5);

        apply_reset();

        // port 1 reads preloaded tile (3,2) -> address 45
        start_cmd(1, 1'b0, 3, 2, 0);
        drain();
        chk("rd_gnt_latency", lat[1], 1);

        // all ports requesting continuously: 0,1,2,0,1,2
        apply_reset();
        for (int p = 0; p < 3; p++) start_cmd(p, 1'b0, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 0);
        grant_log.delete();
        for (int c = 0; c < 40 && grant_log.size() < 6; c++) begin
            @(negedge clock_50);
            service(2);
        end
        chk("rr_grants_seen", (grant_log.size() >= 6) ? 1 : 0, 1);
        for (int i = 0; i < 6; i++) if (i < grant_log.size()) chk("rr_order", grant_log[i], i % 3);
        drain();

        // port 2 write then read back at the last tile
        start_cmd(2, 1'b1, 20, 20, 3'b010);
        drain();
        start_cmd(2, 1'b0, 20, 20, 0);
        drain();

        // out-of-range read
        start_cmd(0, 1'b0, 21, 0, 0);
        drain();

        for (int c = 0; c < 500; c++) begin
            @(negedge clock_50);
            service(1);
        end
        drain();

        // fill with a pending request; fill_start held into FILL must be ignored
        start_cmd(1, 1'b0, 5, 5, 0);
        fill_start = 1'b1; fill_value = 3'b011;
        k = 0; done = 0; gb = 0; got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clock_50);
            if (c == 1) fill_start = 1'b0;
            if (busy) begin
                chk("fill_wren", ram_wren, 1);
                chk("fill_addr", ram_addr, k);
                chk("fill_data", ram_data, 3'b011);
                if (gnt != 3'b000) gb++;
                k++;
            end
            if (fill_done) begin
                done++;
                for (int y = 0; y < MAP_H; y++)
                    for (int x = 0; x < MAP_W; x++) model_map[y][x] = 3'b011;
            end
            if (gnt[1]) got = 1'b1;
            service(0);
        end
        chk("fill_busy_cycles", k, 441);
        chk("fill_done_pulses", done, 1);
        chk("gnt_during_fill", gb, 0);
        chk("gnt_after_fill", got, 1);
        drain();

        for (int c = 0; c < 200; c++) begin
            @(negedge clock_50);
            service(1);
        end
        drain();

        // reset while a read is in flight and a fill has just started
        start_cmd(0, 1'b0, 4, 4, 0);
        @(negedge clock_50);
        chk("rm_gnt", gnt[0], 1);
        service(0);
        fill_start = 1'b1; fill_value = 3'b100;
        @(posedge clock_50);
        #2 resetn = 1'b0;
        fill_start = 1'b0;
        #1 check_all_zero("rm");
        for (int p = 0; p < 3; p++) exp_q[p].delete();
        repeat (2) @(negedge clock_50);
        resetn = 1'b1;
        cb = 0; cr = 0; cw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock_50);
            if (busy) cb++;
            if (rvalid != 3'b000) cr++;
            if (ram_wren) cw++;
            service(0);
        end
        chk("rm_busy_after", cb, 0);
        chk("rm_rvalid_after", cr, 0);
        chk("rm_wren_after", cw, 0);
        start_cmd(0, 1'b0, 4, 4, 0);
        drain();
        chk("rm_idle_gnt_latency", lat[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
